adder_tree_accum_ctrl: RTL and testbench
========================================

Name: adder_tree_accum_ctrl

Overview:
Sequencer that streams a programmable number of 16-element signed vectors through one internal instance of the team's combinational signed 16-input adder tree. It accumulates the per-vector sums into a wide signed accumulator and returns the total through a valid/ready result port. It sits between a vector producer, such as an activation buffer, and a downstream consumer, such as a requantiser, and is the standard way to reduce more than 16 operands with the tree.

Parameters:
- WIDTH, 4, signed width of each input element.
- N_INPUTS, 16, elements per beat. Fixed to match the tree; elaboration fails on any other value.
- MAX_BEATS, 16, maximum vectors per job. Must be a power of 2 and at least 2.
- TREE_W, WIDTH+$clog2(N_INPUTS), tree output width. Derived; do not override.
- ACC_WIDTH, TREE_W+$clog2(MAX_BEATS), accumulator and result width. Derived; do not override.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: job request. Sampled only in IDLE.
- num_beats, in, $clog2(MAX_BEATS)+1: vectors in the job, 0..MAX_BEATS. Latched on an accepted start.
- busy, out, 1: high in every state except IDLE.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input beat ready.
- in_data, in, N_INPUTS*WIDTH: element i occupies bits [i*WIDTH +: WIDTH], two's complement.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result accepted by the consumer.
- out_sum, out, ACC_WIDTH signed: job total.

Behaviour:
- Reset: all registers clear immediately. Outputs take these values:
  - busy=0, in_ready=0, out_valid=0, out_sum=0.
  - FSM enters IDLE.
  - An in-flight job is discarded without any output.
- FSM has four states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE, start=1, num_beats=0: acc is cleared and the FSM goes to DONE. out_valid rises on the next cycle with out_sum=0.
  - IDLE, start=1, num_beats>MAX_BEATS: treated as MAX_BEATS.
  - IDLE, start=1, otherwise: acc is cleared, remaining=num_beats, and the FSM goes to ACCUM.
  - ACCUM: in_ready=1, combinationally equal to (state==ACCUM).
    - A beat transfers on in_valid&&in_ready, with no other gating.
    - Each transfer decrements remaining.
    - The transfer that takes remaining from 1 to 0 sends the FSM to DRAIN. in_ready is already 0 on the next cycle.
  - DRAIN: in_ready=0. The FSM waits until the pipeline stage holding the last beat has been added into acc, then goes to DONE.
  - DONE: out_valid=1 and out_sum=acc, both held stable until out_ready=1. On the handshake cycle the FSM goes to IDLE and out_valid drops on the next cycle.
  - start outside IDLE is ignored and does not queue.
- Datapath pipeline:
  - Stage 1: on a transfer, the tree output (TREE_W signed) is captured in s1_sum along with s1_valid=1 and s1_last.
  - Stage 2: when s1_valid=1, acc <= acc + sign_extend(s1_sum).
  - Throughput is 1 beat per clock.
  - The last beat transfers at edge k. out_valid is high after edge k+2. out_valid is never high with an addition pending.
- Arithmetic:
  - All values are signed two's complement.
  - ACC_WIDTH is sized for worst case N_INPUTS*MAX_BEATS*(-2^(WIDTH-1)), so overflow is impossible. No saturation logic is present.
- out_sum drives acc directly, so it is valid only while out_valid=1. Consumers must not sample it otherwise.
- Back-pressure: in_valid low in ACCUM simply stalls, with no timeout.
- out_ready high in any state other than DONE has no effect.

Test Plan:
1. Single beat of elements 0..7,-8..-1 with num_beats=1 -> out_valid 3 cycles after start plus transfer, out_sum=-8. busy falls the cycle after the out_ready handshake.
2. num_beats=16, all elements -8 every beat, in_valid held high -> in_ready high exactly 16 cycles, out_sum=-2048, out_valid 2 cycles after the last transfer.
3. num_beats=4, beats all 7, all 1, all -1, all 0, with in_valid gaps of 1-3 cycles between beats -> out_sum=112, no beat double-counted.
4. num_beats=0 -> in_ready never rises and out_sum=0. A second start with num_beats=2 and all-7 beats is pulsed during DONE and is ignored. out_ready is held low for 5 cycles with out_valid/out_sum stable, then released. After the handshake the same num_beats=2 job is restarted from IDLE -> out_sum=224.
5. Assert rst mid-ACCUM after 3 of 8 beats -> outputs clear in the same cycle without a clock edge. A new num_beats=1 job with all 1s -> out_sum=16, with no residue from the aborted job.
6. Back-to-back jobs: start reasserted in the first IDLE cycle after a handshake -> second job accepted. Results of both jobs are correct and independent.

Source files
------------

// File: rtl/adder_tree_accum_ctrl_if.sv
// Job-control, input-beat and result handshake bundle for adder_tree_accum_ctrl.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface adder_tree_accum_ctrl_if #(
   parameter int WIDTH     = 4,
   parameter int N_INPUTS  = 16,
   parameter int MAX_BEATS = 16
);
   localparam int TREE_W    = WIDTH + $clog2(N_INPUTS);
   localparam int ACC_WIDTH = TREE_W + $clog2(MAX_BEATS);
   localparam int NB_W      = $clog2(MAX_BEATS) + 1;

   logic                        start;
   logic [NB_W-1:0]             num_beats;
   logic                        busy;
   logic                        in_valid;
   logic                        in_ready;
   logic [N_INPUTS*WIDTH-1:0]   in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [ACC_WIDTH-1:0] out_sum;

   modport master (
      output start, num_beats, in_valid, in_data, out_ready,
      input  busy, in_ready, out_valid, out_sum
   );

   modport slave (
      input  start, num_beats, in_valid, in_data, out_ready,
      output busy, in_ready, out_valid, out_sum
   );
endinterface

// File: rtl/adder_tree_accum_ctrl.sv
// Streams num_beats signed 16-element vectors through a combinational adder
// tree, accumulates the per-vector sums and returns the total on a
// valid/ready result port. Two-stage datapath: tree capture, then accumulate.
module adder_tree_accum_ctrl #(
   parameter int WIDTH     = 4,
   parameter int N_INPUTS  = 16,
   parameter int MAX_BEATS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   adder_tree_accum_ctrl_if.slave bus
);
   localparam int TREE_W    = WIDTH + $clog2(N_INPUTS);
   localparam int ACC_WIDTH = TREE_W + $clog2(MAX_BEATS);
   localparam int NB_W      = $clog2(MAX_BEATS) + 1;

   if (N_INPUTS != 16) begin : g_bad_n_inputs
      $error("adder_tree_accum_ctrl: N_INPUTS must be 16");
   end
   if ((MAX_BEATS < 2) || ((MAX_BEATS & (MAX_BEATS - 1)) != 0)) begin : g_bad_max_beats
      $error("adder_tree_accum_ctrl: MAX_BEATS must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      DONE
   } state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic [NB_W-1:0]             remaining;
   logic [NB_W-1:0]             nb_clamped;
   logic                        accept;
   logic                        xfer;
   logic signed [WIDTH-1:0]     elem;
   logic signed [TREE_W-1:0]    tree_sum;
   logic signed [TREE_W-1:0]    s1_sum;
   logic                        s1_valid;
   logic                        s1_last;
   logic signed [ACC_WIDTH-1:0] acc;

   // Signed reduction of the 16 elements of the current beat
   always_comb begin
      elem     = '0;
      tree_sum = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         elem     = bus.in_data[i*WIDTH +: WIDTH];
         tree_sum = tree_sum + {{(TREE_W-WIDTH){elem[WIDTH-1]}}, elem};
      end
   end

   // Job acceptance, beat transfer and beat-count clamping
   always_comb begin
      accept     = (state == IDLE) && bus.start;
      xfer       = bus.in_valid && (state == ACCUM);
      nb_clamped = (bus.num_beats > NB_W'(MAX_BEATS)) ? NB_W'(MAX_BEATS) : bus.num_beats;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt     = state;
      bus.busy      = (state != IDLE);
      bus.in_ready  = (state == ACCUM);
      bus.out_valid = (state == DONE);
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.num_beats == '0) ? DONE : ACCUM;
         ACCUM:   if (xfer && (remaining == NB_W'(1))) state_nxt = DRAIN;
         // Leave only once the last beat has left stage 1 and been added
         DRAIN:   if (!(s1_valid && s1_last)) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and remaining-beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         if (accept) remaining <= nb_clamped;
         else if (xfer) remaining <= remaining - NB_W'(1);
      end
   end

   // Stage 1: capture the tree output of each transferred beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sum   <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= xfer;
         if (xfer) begin
            s1_sum  <= tree_sum;
            s1_last <= (remaining == NB_W'(1));
         end
      end
   end

   // Stage 2: sign-extend and accumulate; cleared when a job is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (accept) begin
         acc <= '0;
      end else if (s1_valid) begin
         acc <= acc + {{(ACC_WIDTH-TREE_W){s1_sum[TREE_W-1]}}, s1_sum};
      end
   end

   assign bus.out_sum = acc;
endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Scoreboard bench for adder_tree_accum_ctrl: expected job totals are queued
// as beats are driven and compared when the result handshake appears.
module tb_adder_tree_accum_ctrl;
   localparam int WIDTH     = 4;
   localparam int N_INPUTS  = 16;
   localparam int MAX_BEATS = 16;

   logic clk = 1'b0;
   logic rst;

   adder_tree_accum_ctrl_if #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .MAX_BEATS(MAX_BEATS)) bus ();

   adder_tree_accum_ctrl #(.WIDTH(WIDTH), .N_INPUTS(N_INPUTS), .MAX_BEATS(MAX_BEATS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int     chk_cnt   = 0;
   int     pass_cnt  = 0;
   int     ready_cnt = 0;
   longint exp_q[$];
   int     beat_vals[$];

   task automatic check(input string tag, input longint obs, input longint exp);
      chk_cnt++;
      if (obs == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Advance one cycle; sample just after the falling edge
   task automatic tick();
      @(negedge clk);
      #1;
      if (bus.in_ready) ready_cnt++;
   endtask

   task automatic push_const(input int v);
      for (int i = 0; i < N_INPUTS; i++) beat_vals.push_back(v);
   endtask

   task automatic push_random();
      for (int i = 0; i < N_INPUTS; i++) beat_vals.push_back(int'($urandom_range(0, 15)) - 8);
   endtask

   task automatic drive_beat(input int b);
      for (int i = 0; i < N_INPUTS; i++)
         bus.in_data[i*WIDTH +: WIDTH] = WIDTH'(beat_vals[b*N_INPUTS + i]);
   endtask

   task automatic start_job(input int nb);
      bus.start     = 1'b1;
      bus.num_beats = 5'(nb);
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic run_job(input string tag, input int nb, input int gap_max,
                          input int hold, input bit pulse_ign);
      longint exp = 0;
      int eff = (nb > MAX_BEATS) ? MAX_BEATS : nb;
      int exp_ready = eff;
      int r0, lat, w, gap;
      for (int b = 0; b < eff; b++)
         for (int i = 0; i < N_INPUTS; i++) exp += beat_vals[b*N_INPUTS + i];
      exp_q.push_back(exp);
      r0 = ready_cnt;
      start_job(nb);
      for (int b = 0; b < eff; b++) begin
         gap = (b > 0 && gap_max > 0) ? int'($urandom_range(1, gap_max)) : 0;
         exp_ready += gap;
         bus.in_valid = 1'b0;
         repeat (gap) tick();
         drive_beat(b);
         bus.in_valid = 1'b1;
         w = 0;
         while (!bus.in_ready && w < 20) begin tick(); w++; end
         tick();
         bus.in_valid = 1'b0;
      end
      lat = 0;
      while (!bus.out_valid && lat < 50) begin tick(); lat++; end
      check({tag, "_latency"}, lat, (eff == 0) ? 0 : 2);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd999999;
      check({tag, "_sum"}, longint'(bus.out_sum), exp);
      check({tag, "_busy_done"}, bus.busy, 1);
      for (int h = 0; h < hold; h++) begin
         if (pulse_ign && h == 1) begin
            bus.start     = 1'b1;
            bus.num_beats = 5'd2;
         end
         tick();
         bus.start = 1'b0;
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_sum"}, longint'(bus.out_sum), exp);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, bus.out_valid, 0);
      check({tag, "_busy_drop"}, bus.busy, 0);
      check({tag, "_ready_cycles"}, ready_cnt - r0, exp_ready);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_beats = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", longint'(bus.out_sum), 0);
      rst = 1'b0;
      tick();

      // Single beat 0..7, -8..-1
      beat_vals = {};
      for (int i = 0; i < N_INPUTS; i++) beat_vals.push_back((i < 8) ? i : i - 16);
      run_job("t1", 1, 0, 0, 1'b0);

      // Full job of minimum values, in_valid held high
      beat_vals = {};
      repeat (16) push_const(-8);
      run_job("t2", 16, 0, 0, 1'b0);

      // Four beats with input gaps
      beat_vals = {};
      push_const(7); push_const(1); push_const(-1); push_const(0);
      run_job("t3", 4, 3, 0, 1'b0);

      // Zero-beat job with ignored start during DONE and held result
      run_job("t4a", 0, 0, 5, 1'b1);
      beat_vals = {};
      repeat (2) push_const(7);
      run_job("t4b", 2, 0, 0, 1'b0);

      // Over-range beat count clamps to MAX_BEATS
      beat_vals = {};
      repeat (16) push_const(1);
      run_job("clamp", 31, 0, 0, 1'b0);

      // Reset mid-ACCUM after 3 of 8 beats
      beat_vals = {};
      repeat (8) push_const(2);
      start_job(8);
      for (int b = 0; b < 3; b++) begin
         drive_beat(b);
         bus.in_valid = 1'b1;
         tick();
         bus.in_valid = 1'b0;
      end
      tick();
      check("t5_acc_pre", longint'(bus.out_sum), 96);
      check("t5_busy_pre", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_busy", bus.busy, 0);
      check("t5_rst_in_ready", bus.in_ready, 0);
      check("t5_rst_out_valid", bus.out_valid, 0);
      check("t5_rst_out_sum", longint'(bus.out_sum), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      beat_vals = {};
      push_const(1);
      run_job("t5", 1, 0, 0, 1'b0);

      // Back-to-back jobs, second started in the first IDLE cycle
      beat_vals = {};
      repeat (3) push_random();
      run_job("t6a", 3, 0, 0, 1'b0);
      beat_vals = {};
      repeat (2) push_random();
      run_job("t6b", 2, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
